// File: rtl/dmem_responder.sv
// Data-memory responder for the core's DMEM port: single-port word RAM with
// write-first read, stale-fetch refetch with a one-cycle pause, and fault counting.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ask_addr,
  input  logic        ask_we,
  input  logic [31:0] ask_wdata,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic [31:0] rdata,
  output logic        pause,
  output logic        addr_fault,
  output logic [15:0] fault_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

  typedef enum logic {IDLE, REFETCH} state_t;

  state_t                  state;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rd_q;
  logic [31:0]             last_addr;
  logic                    last_ok;

  logic                    miss;
  logic [31:0]             rd_addr;
  logic [31:0]             rd_off;
  logic                    rd_ok;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [31:0]             ask_off;
  logic                    ask_ok;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic                    wr_en;
  logic                    fault;

  always_comb begin
    miss    = fetch_valid && (fetch_addr != last_addr);
    // Reset masks the hold request so the core never stalls while held in reset.
    pause   = !reset && (state == IDLE) && miss;

    rd_addr = pause ? fetch_addr : ask_addr;
    rd_off  = rd_addr - BASE_ADDR;
    rd_ok   = (rd_addr[1:0] == 2'b00) && ({1'b0, rd_off} < SPAN);
    rd_idx  = rd_off[ADDR_WIDTH+1:2];

    ask_off = ask_addr - BASE_ADDR;
    ask_ok  = (ask_addr[1:0] == 2'b00) && ({1'b0, ask_off} < SPAN);
    wr_idx  = ask_off[ADDR_WIDTH+1:2];

    // A store seen during a pause is retried by the core, so it is dropped here.
    wr_en   = !reset && !pause && ask_we && ask_ok;
    fault   = !pause && ((ask_we && !ask_ok) || (fetch_valid && !miss && !last_ok));

    rdata   = last_ok ? rd_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_q        <= '0;
      last_addr   <= '1;
      last_ok     <= 1'b0;
      addr_fault  <= 1'b0;
      fault_count <= '0;
    end else begin
      state      <= pause ? REFETCH : IDLE;
      // When writing, the read address equals the write address: write-first.
      rd_q       <= wr_en ? ask_wdata : mem[rd_idx];
      last_addr  <= rd_addr;
      last_ok    <= rd_ok;
      addr_fault <= fault;
      if (fault && (fault_count != '1))
        fault_count <= fault_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= ask_wdata;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the CPU core's DMEM port.
- Takes the early "ask" address, write enable and write data during ID, and returns load data combinationally during EXE against the latched fetch address.
- Holds a word-addressed on-chip synchronous RAM.
- Detects a stale read (fetch address differs from the address actually read), re-reads, and raises `pause` for exactly one cycle to hold the pipeline.
- Flags and counts misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h1001_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ask_addr  in  32  byte address presented by the core in ID.
- ask_we  in  1  store request in ID.
- ask_wdata  in  32  store data.
- fetch_addr  in  32  byte address of the load currently in EXE.
- fetch_valid  in  1  EXE holds a load; decoded at core integration.
- rdata  out  32  load data for the EXE stage (combinational from internal state).
- pause  out  1  pipeline hold request (combinational).
- addr_fault  out  1  registered one-cycle pulse on a bad access.
- fault_count  out  16  saturating count of bad accesses.

Behaviour:
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - ok(addr) = (addr[1:0]==0) && (off < 4 << ADDR_WIDTH).
  - idx = off[ADDR_WIDTH+1:2].
- State: FSM {IDLE, REFETCH}; rd_q[31:0]; last_addr[31:0]; last_ok.
- Reset (async): state=IDLE, rd_q=0, last_addr=32'hFFFF_FFFF, last_ok=0, addr_fault=0, fault_count=0. RAM contents are not reset.
- miss = fetch_valid && (fetch_addr != last_addr).
- pause = (state==IDLE && miss). pause is 0 in REFETCH.
- IDLE, no miss, each cycle:
  - Read port address = ask_addr: rd_q <= mem[idx(ask_addr)], last_addr <= ask_addr, last_ok <= ok(ask_addr).
  - If ask_we && ok(ask_addr): mem[idx] <= ask_wdata. Write-first: same-cycle rd_q gets ask_wdata.
- IDLE with miss:
  - Writes suppressed; the core holds ID, so the store retries after pause drops and lands exactly once.
  - Read port address = fetch_addr: rd_q, last_addr and last_ok are loaded from fetch_addr.
  - Next state = REFETCH.
- REFETCH (1 cycle):
  - fetch_addr now matches last_addr, so rdata is valid; pause=0.
  - Read/write behaves as in IDLE using ask_*; next state = IDLE.
- rdata = last_ok ? rd_q : 32'h0.
  - When fetch_valid=0, rdata is don't-care but still follows this rule.
- Fault sources, evaluated in cycles where pause=0:
  - ask_we && !ok(ask_addr): write dropped.
  - fetch_valid && !miss && !last_ok.
- addr_fault: registered. Set for one cycle following any cycle with a fault source, else 0.
- fault_count: increments by 1 per faulting cycle (two sources in the same cycle count once), saturates at 16'hFFFF.
- Reset mid-REFETCH: returns to IDLE immediately; no write occurs.
- Back-to-back misses: at most one pause cycle per distinct fetch_addr; never two consecutive pause cycles.
- Latency: load data is valid in the cycle after its ask with no stall, or 1 extra cycle on a miss.

Test Plan:
- Store then load: write 32'hDEADBEEF at BASE_ADDR+8, load the same address next instruction → rdata=32'hDEADBEEF, pause never asserted.
- Same-cycle write and read: ask_we=1, ask_addr=BASE_ADDR+4, wdata=32'h1234 → next cycle rd_q=32'h1234 (write-first).
- Stale fetch: last_addr=BASE_ADDR, fetch_valid=1, fetch_addr=BASE_ADDR+0x10 (holding 32'hA5A5) → pause=1 for exactly one cycle, then rdata=32'hA5A5 with pause=0.
- Store during miss cycle: miss with ask_we=1, ask_addr=BASE_ADDR+0x20, wdata=7 → memory unchanged during the pause cycle, written once in the REFETCH cycle; readback=7.
- Faults: write to BASE_ADDR+2, then load from BASE_ADDR+0x1000 (ADDR_WIDTH=10) → write dropped, load returns 0, two addr_fault pulses, fault_count=2. Preload fault_count near 16'hFFFF and confirm saturation.
- Reset asserted during REFETCH → outputs at reset values asynchronously, pause=0, state IDLE after release.
